// File: rtl/rib_arb.sv
// rib_arb: fixed-priority (m2 > m0 > m1) three-master arbiter for the core's single RIB slave port.
// Define RIB_ARB_TIMEOUT_EN to enable the watchdog that terminates unacknowledged accesses.
module rib_arb #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   output logic [DATA_W-1:0] m0_data_o,
   output logic              m0_ack_o,

   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   output logic [DATA_W-1:0] m1_data_o,
   output logic              m1_ack_o,

   input  logic              m2_req_i,
   input  logic              m2_we_i,
   input  logic [ADDR_W-1:0] m2_addr_i,
   input  logic [DATA_W-1:0] m2_data_i,
   output logic [DATA_W-1:0] m2_data_o,
   output logic              m2_ack_o,

   output logic              s_req_o,
   output logic              s_we_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_data_o,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_ack_i,

   output logic              hold_flag_o,
   output logic              err_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [1:0]  gnt_q;
   logic [1:0]  gnt_d;
   logic [1:0]  sel;
   logic        active;
   logic        done;
   logic        to_fire;
   logic [3:0]  ack_vec;
   logic [DATA_W-1:0] rdata;

   logic [3:0]        req_vec;
   logic [3:0]        we_vec;
   logic [ADDR_W-1:0] addr_arr [4];
   logic [DATA_W-1:0] wdata_arr [4];

   // Index 3 is an unused slot so a 2-bit grant index never selects out of range.
   assign req_vec = {1'b0, m2_req_i, m1_req_i, m0_req_i};
   assign we_vec  = {1'b0, m2_we_i,  m1_we_i,  m0_we_i};

   always_comb begin
      addr_arr[0]  = m0_addr_i;
      addr_arr[1]  = m1_addr_i;
      addr_arr[2]  = m2_addr_i;
      addr_arr[3]  = '0;
      wdata_arr[0] = m0_data_i;
      wdata_arr[1] = m1_data_i;
      wdata_arr[2] = m2_data_i;
      wdata_arr[3] = '0;
   end

`ifdef RIB_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt_q;
   logic       to_hit;

   assign to_hit = (cnt_q == TO_LAST);

   // Counts WAIT cycles that end still waiting; any exit to IDLE clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (state_q == S_WAIT && state_d == S_WAIT) begin
         cnt_q <= cnt_q + 8'd1;
      end else begin
         cnt_q <= '0;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         gnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
      end
   end

   // Grant decision and next state; everything is forced quiet while reset is low.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel     = 2'd0;
      active  = 1'b0;
      done    = 1'b0;
      to_fire = 1'b0;
      if (rst) begin
         case (state_q)
            S_IDLE: begin
               if (m2_req_i) begin
                  sel    = 2'd2;
                  active = 1'b1;
               end else if (m0_req_i) begin
                  sel    = 2'd0;
                  active = 1'b1;
               end else if (m1_req_i) begin
                  sel    = 2'd1;
                  active = 1'b1;
               end
               if (active) begin
                  if (s_ack_i) begin
                     done = 1'b1;
                  end else begin
                     state_d = S_WAIT;
                     gnt_d   = sel;
                  end
               end
            end
            S_WAIT: begin
               sel    = gnt_q;
               active = req_vec[gnt_q];
               if (!active) begin
                  state_d = S_IDLE;
               end else if (s_ack_i) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end
`ifdef RIB_ARB_TIMEOUT_EN
               else if (to_hit) begin
                  to_fire = 1'b1;
                  state_d = S_IDLE;
               end
`endif
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      ack_vec = 4'b0000;
      rdata   = '0;
      if (done) begin
         ack_vec[sel] = 1'b1;
         rdata        = we_vec[sel] ? '0 : s_data_i;
      end else if (to_fire) begin
         ack_vec[sel] = 1'b1;
         rdata        = DATA_W'(32'hDEADBEEF);
      end
   end

   assign s_req_o  = active;
   assign s_we_o   = active & we_vec[sel];
   assign s_addr_o = active ? addr_arr[sel]  : '0;
   assign s_data_o = active ? wdata_arr[sel] : '0;

   assign m0_ack_o  = ack_vec[0];
   assign m1_ack_o  = ack_vec[1];
   assign m2_ack_o  = ack_vec[2];
   assign m0_data_o = ack_vec[0] ? rdata : '0;
   assign m1_data_o = ack_vec[1] ? rdata : '0;
   assign m2_data_o = ack_vec[2] ? rdata : '0;

   // JTAG (m2) waits deliberately never stall the core.
   assign hold_flag_o = rst & ((m0_req_i & ~ack_vec[0]) | (m1_req_i & ~ack_vec[1]));

`ifdef RIB_ARB_TIMEOUT_EN
   assign err_o = to_fire;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rib_arb.sv
// tb_rib_arb: directed-vector self-checking bench for rib_arb.
module tb_rib_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m2_req_i, m2_we_i;
   logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i, m2_addr_i, m2_data_i;
   logic [31:0] m0_data_o, m1_data_o, m2_data_o;
   logic        m0_ack_o, m1_ack_o, m2_ack_o;
   logic        s_req_o, s_we_o, s_ack_i, hold_flag_o, err_o;
   logic [31:0] s_addr_o, s_data_o, s_data_i;

   int checkCount = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   rib_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
      .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
      .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
      .m2_req_i(m2_req_i), .m2_we_i(m2_we_i), .m2_addr_i(m2_addr_i), .m2_data_i(m2_data_i),
      .m2_data_o(m2_data_o), .m2_ack_o(m2_ack_o),
      .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
      .s_data_i(s_data_i), .s_ack_i(s_ack_i),
      .hold_flag_o(hold_flag_o), .err_o(err_o)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
      end
   endtask

   // Inputs change 2 time units after a rising edge; checks follow 2 units later.
   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [2:0] req, input logic [2:0] we,
                                input logic ack, input logic [31:0] sdata);
      m0_req_i = req[0];
      m1_req_i = req[1];
      m2_req_i = req[2];
      m0_we_i  = we[0];
      m1_we_i  = we[1];
      m2_we_i  = we[2];
      s_ack_i  = ack;
      s_data_i = sdata;
      #2;
   endtask

   initial begin
      rst       = 1'b0;
      m0_addr_i = 32'h1000_0000;
      m1_addr_i = 32'h0000_0100;
      m2_addr_i = 32'h0000_2000;
      m0_data_i = 32'h0000_00A5;
      m1_data_i = 32'h0000_0011;
      m2_data_i = 32'h0000_0022;
      applyStimulus(3'b000, 3'b000, 1'b0, 32'h0);

      // Reset held low: outputs stay quiet even with a request and an ack present.
      nextCycle();
      applyStimulus(3'b001, 3'b000, 1'b1, 32'h77);
      checkOutput("rst_s_req", {31'b0, s_req_o}, 32'd0);
      checkOutput("rst_hold", {31'b0, hold_flag_o}, 32'd0);
      checkOutput("rst_m0_ack", {31'b0, m0_ack_o}, 32'd0);

      nextCycle();
      rst = 1'b1;
      applyStimulus(3'b000, 3'b000, 1'b0, 32'h0);
      checkOutput("idle_s_req", {31'b0, s_req_o}, 32'd0);
      checkOutput("idle_err", {31'b0, err_o}, 32'd0);

      // Zero-wait read on m1.
      nextCycle();
      applyStimulus(3'b010, 3'b000, 1'b1, 32'h13);
      checkOutput("zw_m1_ack", {31'b0, m1_ack_o}, 32'd1);
      checkOutput("zw_m1_data", m1_data_o, 32'h13);
      checkOutput("zw_hold", {31'b0, hold_flag_o}, 32'd0);
      checkOutput("zw_s_addr", s_addr_o, 32'h100);
      nextCycle();
      applyStimulus(3'b000, 3'b000, 1'b0, 32'h0);

      // m0 write, slave acks in the 4th cycle.
      for (int c = 0; c < 4; c++) begin
         nextCycle();
         applyStimulus(3'b001, 3'b001, (c == 3), 32'h55);
         checkOutput("wr_s_we", {31'b0, s_we_o}, 32'd1);
         checkOutput("wr_s_data", s_data_o, 32'hA5);
         checkOutput("wr_hold", {31'b0, hold_flag_o}, (c < 3) ? 32'd1 : 32'd0);
         checkOutput("wr_m0_ack", {31'b0, m0_ack_o}, (c == 3) ? 32'd1 : 32'd0);
         checkOutput("wr_m0_data", m0_data_o, 32'h0);
      end
      nextCycle();
      applyStimulus(3'b000, 3'b000, 1'b0, 32'h0);

      // All three request; slave has one wait cycle; each master drops req after its ack.
      nextCycle();
      applyStimulus(3'b111, 3'b000, 1'b0, 32'h0);
      checkOutput("all_c0_addr", s_addr_o, 32'h2000);
      checkOutput("all_c0_hold", {31'b0, hold_flag_o}, 32'd1);
      nextCycle();
      applyStimulus(3'b111, 3'b000, 1'b1, 32'h22);
      checkOutput("all_c1_m2_ack", {31'b0, m2_ack_o}, 32'd1);
      checkOutput("all_c1_m2_data", m2_data_o, 32'h22);
      checkOutput("all_c1_m0_ack", {31'b0, m0_ack_o}, 32'd0);
      checkOutput("all_c1_m0_data", m0_data_o, 32'h0);
      nextCycle();
      applyStimulus(3'b011, 3'b000, 1'b0, 32'h0);
      checkOutput("all_c2_addr", s_addr_o, 32'h1000_0000);
      nextCycle();
      applyStimulus(3'b011, 3'b000, 1'b1, 32'h33);
      checkOutput("all_c3_m0_ack", {31'b0, m0_ack_o}, 32'd1);
      checkOutput("all_c3_m0_data", m0_data_o, 32'h33);
      checkOutput("all_c3_hold", {31'b0, hold_flag_o}, 32'd1);
      nextCycle();
      applyStimulus(3'b010, 3'b000, 1'b0, 32'h0);
      checkOutput("all_c4_addr", s_addr_o, 32'h100);
      nextCycle();
      applyStimulus(3'b010, 3'b000, 1'b1, 32'h44);
      checkOutput("all_c5_m1_ack", {31'b0, m1_ack_o}, 32'd1);
      checkOutput("all_c5_m1_data", m1_data_o, 32'h44);
      checkOutput("all_c5_hold", {31'b0, hold_flag_o}, 32'd0);
      nextCycle();
      applyStimulus(3'b000, 3'b000, 1'b0, 32'h0);

      // m1 in WAIT must not be preempted by later m0/m2 requests.
      nextCycle();
      applyStimulus(3'b010, 3'b000, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(3'b111, 3'b000, 1'b0, 32'h0);
      checkOutput("np_addr", s_addr_o, 32'h100);
      nextCycle();
      applyStimulus(3'b111, 3'b000, 1'b1, 32'h5A);
      checkOutput("np_m1_ack", {31'b0, m1_ack_o}, 32'd1);
      checkOutput("np_m2_ack", {31'b0, m2_ack_o}, 32'd0);
      checkOutput("np_m1_data", m1_data_o, 32'h5A);
      nextCycle();
      applyStimulus(3'b000, 3'b000, 1'b0, 32'h0);

      // m0 abort after two WAIT cycles; the late ack is ignored.
      nextCycle();
      applyStimulus(3'b001, 3'b000, 1'b0, 32'h0);
      checkOutput("ab_c0_s_req", {31'b0, s_req_o}, 32'd1);
      nextCycle();
      applyStimulus(3'b001, 3'b000, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(3'b001, 3'b000, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(3'b000, 3'b000, 1'b1, 32'h99);
      checkOutput("ab_s_req", {31'b0, s_req_o}, 32'd0);
      checkOutput("ab_m0_ack", {31'b0, m0_ack_o}, 32'd0);
      nextCycle();
      applyStimulus(3'b010, 3'b000, 1'b1, 32'h13);
      checkOutput("ab_idle_m1_ack", {31'b0, m1_ack_o}, 32'd1);
      nextCycle();
      applyStimulus(3'b000, 3'b000, 1'b0, 32'h0);

      // Reset asserted mid-WAIT, then a fresh m0 access.
      nextCycle();
      applyStimulus(3'b001, 3'b000, 1'b0, 32'h0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(3'b001, 3'b000, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(3'b001, 3'b000, 1'b1, 32'h66);
      checkOutput("mr_s_req", {31'b0, s_req_o}, 32'd0);
      checkOutput("mr_m0_ack", {31'b0, m0_ack_o}, 32'd0);
      checkOutput("mr_hold", {31'b0, hold_flag_o}, 32'd0);
      checkOutput("mr_s_addr", s_addr_o, 32'h0);
      nextCycle();
      rst = 1'b1;
      applyStimulus(3'b010, 3'b000, 1'b1, 32'h66);
      checkOutput("mr_idle_m1_ack", {31'b0, m1_ack_o}, 32'd1);
      nextCycle();
      applyStimulus(3'b001, 3'b000, 1'b0, 32'h0);
      checkOutput("mr_m0_addr", s_addr_o, 32'h1000_0000);
      nextCycle();
      applyStimulus(3'b001, 3'b000, 1'b1, 32'h77);
      checkOutput("mr_m0_ack2", {31'b0, m0_ack_o}, 32'd1);
      checkOutput("mr_m0_data", m0_data_o, 32'h77);
      nextCycle();
      applyStimulus(3'b000, 3'b000, 1'b0, 32'h0);

`ifdef RIB_ARB_TIMEOUT_EN
      // Watchdog: m1 never acked; the 4th WAIT cycle terminates it.
      for (int c = 0; c < 5; c++) begin
         nextCycle();
         applyStimulus(3'b010, 3'b000, 1'b0, 32'h0);
         checkOutput("to_m1_ack", {31'b0, m1_ack_o}, (c == 4) ? 32'd1 : 32'd0);
         checkOutput("to_err", {31'b0, err_o}, (c == 4) ? 32'd1 : 32'd0);
         checkOutput("to_m1_data", m1_data_o, (c == 4) ? 32'hDEADBEEF : 32'h0);
      end
      nextCycle();
      applyStimulus(3'b000, 3'b000, 1'b0, 32'h0);
      checkOutput("to_err_after", {31'b0, err_o}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
